// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter/receiver state encoding, frame
// width and the baud-divisor helper.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // Clock cycles per serial bit; integer truncation.
    function automatic int calc_baud_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/sync_fifo_param.sv
// Synchronous circular-buffer FIFO with registered full/empty/level.
// A write is accepted only when not full at the start of the cycle; a pop
// in the same cycle does not make room for it. The head entry is always
// visible on o_rd_data (first-word fall-through).
// Ports:
//   clk, rst_n    clock, async active-low reset
//   i_wr_en       push i_wr_data (ignored when full)
//   i_wr_data     write data
//   i_rd_en       pop the head entry (ignored when empty)
//   o_rd_data     current head entry
//   o_full        DEPTH entries held
//   o_empty       no entries held
//   o_level       occupancy, 0..DEPTH
module sync_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_wr_en,
    input  logic [DATA_WIDTH-1:0]        i_wr_data,
    input  logic                         i_rd_en,
    output logic [DATA_WIDTH-1:0]        o_rd_data,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH):0]       o_level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] LVL_FULL = (PTR_W+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W:0]        r_level;
    logic                  r_full;
    logic                  r_empty;

    logic                  w_wr_ok;
    logic                  w_rd_ok;
    logic [PTR_W:0]        w_level_nxt;

    assign w_wr_ok     = i_wr_en & ~r_full;
    assign w_rd_ok     = i_rd_en & ~r_empty;
    assign w_level_nxt = r_level + (PTR_W+1)'(w_wr_ok) - (PTR_W+1)'(w_rd_ok);

    // Storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == LVL_FULL);
            r_empty <= (w_level_nxt == '0);
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_full    = r_full;
    assign o_empty   = r_empty;
    assign o_level   = r_level;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter. Byte writes are queued in a small FIFO and
// serialised LSB first onto tx, which is driven straight from a flop.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   i_wr_en       one-cycle write strike from the UART slave
//   i_wr_data     byte to enqueue
//   i_clr_ovf     clear the sticky overflow flag
//   o_full        FIFO holds FIFO_DEPTH bytes
//   o_empty       FIFO holds no bytes
//   o_level       FIFO occupancy
//   o_busy        frame on the line or bytes still queued
//   o_overflow    sticky, set when a write is dropped
//   tx            serial line, idle high
//
// state | meaning
// IDLE  | line high; pops the head byte as soon as the FIFO is non-empty
// START | start bit (low) for one bit period
// DATA  | eight data bits, LSB first, one bit period each
// STOP  | stop bit (high) for one bit period
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4,
    parameter int PTR_W      = $clog2(FIFO_DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr_en,
    input  logic [7:0]       i_wr_data,
    input  logic             i_clr_ovf,
    output logic             o_full,
    output logic             o_empty,
    output logic [PTR_W:0]   o_level,
    output logic             o_busy,
    output logic             o_overflow,
    output logic             tx
);

    localparam int BAUD_DIV = calc_baud_div(CLK_FREQ, BAUD);
    localparam int CNT_W    = $clog2(BAUD_DIV);
    localparam int IDX_W    = $clog2(UART_DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

    uart_state_t               r_state;
    uart_state_t               w_state_nxt;
    logic [CNT_W-1:0]          r_baud_cnt;
    logic [IDX_W-1:0]          r_bit_idx;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic                      r_tx;
    logic                      r_overflow;

    logic                      w_pop;
    logic                      w_bit_end;
    logic                      w_tx_nxt;
    logic [UART_DATA_BITS-1:0] w_fifo_rd_data;
    logic                      w_fifo_full;
    logic                      w_fifo_empty;

    sync_fifo_param #(
        .DATA_WIDTH (UART_DATA_BITS),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_wr_en    (i_wr_en),
        .i_wr_data  (i_wr_data),
        .i_rd_en    (w_pop),
        .o_rd_data  (w_fifo_rd_data),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty),
        .o_level    (o_level)
    );

    assign w_bit_end = (r_baud_cnt == CNT_LAST);

    // Next tx level is computed alongside the next state so the line flop
    // changes on the same edge as the state it belongs to.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_tx_nxt    = 1'b1;
        unique case (r_state)
            IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = START;
                    w_tx_nxt    = 1'b0;
                end
            end
            START: begin
                w_tx_nxt = 1'b0;
                if (w_bit_end) begin
                    w_state_nxt = DATA;
                    w_tx_nxt    = r_shift[0];
                end
            end
            DATA: begin
                w_tx_nxt = r_shift[0];
                if (w_bit_end) begin
                    if (r_bit_idx == IDX_LAST) begin
                        w_state_nxt = STOP;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_tx_nxt = r_shift[1];
                    end
                end
            end
            STOP: begin
                w_tx_nxt = 1'b1;
                if (w_bit_end) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_tx       <= 1'b1;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tx    <= w_tx_nxt;
            if (w_pop) begin
                r_shift    <= w_fifo_rd_data;
                r_baud_cnt <= '0;
                r_bit_idx  <= '0;
            end else if (r_state != IDLE) begin
                r_baud_cnt <= w_bit_end ? '0 : r_baud_cnt + CNT_W'(1);
                if (w_bit_end && r_state == START) begin
                    r_bit_idx <= '0;
                end
                if (w_bit_end && r_state == DATA) begin
                    r_shift   <= r_shift >> 1;
                    r_bit_idx <= r_bit_idx + IDX_W'(1);
                end
            end
        end
    end

    // A dropped write outranks a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (i_wr_en && w_fifo_full) begin
            r_overflow <= 1'b1;
        end else if (i_clr_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    assign o_full     = w_fifo_full;
    assign o_empty    = w_fifo_empty;
    assign o_busy     = (r_state != IDLE) | ~w_fifo_empty;
    assign o_overflow = r_overflow;
    assign tx         = r_tx;

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

    localparam int BD    = 16;
    localparam int FRAME = 10 * BD;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_wr_en = 1'b0;
    logic [7:0] i_wr_data = 8'h00;
    logic       i_clr_ovf = 1'b0;
    logic       o_full;
    logic       o_empty;
    logic [2:0] o_level;
    logic       o_busy;
    logic       o_overflow;
    logic       tx;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [9:0] q_bits [$];
    int         q_start [$];

    uart_tx_fifo #(
        .CLK_FREQ   (16),
        .BAUD       (1),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_wr_en    (i_wr_en),
        .i_wr_data  (i_wr_data),
        .i_clr_ovf  (i_clr_ovf),
        .o_full     (o_full),
        .o_empty    (o_empty),
        .o_level    (o_level),
        .o_busy     (o_busy),
        .o_overflow (o_overflow),
        .tx         (tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_frames(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (q_bits.size() < n && k < budget) begin
            tick();
            k++;
        end
        check_eq(tag, q_bits.size(), n);
    endtask

    // Line decoder: on a falling edge, samples every bit centre of a frame.
    initial begin : line_mon
        bit         act;
        int         off;
        int         st;
        logic [9:0] bits;
        act  = 1'b0;
        off  = 0;
        st   = 0;
        bits = '0;
        forever begin
            tick();
            if (!rst_n) begin
                act = 1'b0;
            end else begin
                if (!act && tx === 1'b0) begin
                    act = 1'b1;
                    off = 0;
                    st  = cyc;
                end else if (act) begin
                    off++;
                end
                if (act && (off % BD) == BD / 2) begin
                    bits[off / BD] = tx;
                    if (off / BD == 9) begin
                        q_bits.push_back(bits);
                        q_start.push_back(st);
                        act = 1'b0;
                    end
                end
            end
        end
    end

    initial begin : main
        int t;
        int s;
        int bad;
        int nfr;
        logic [7:0] sim_bytes [4];

        // Reset state
        repeat (3) tick();
        check_eq("rst_tx", tx, 1);
        check_eq("rst_empty", o_empty, 1);
        check_eq("rst_full", o_full, 0);
        check_eq("rst_level", o_level, 0);
        check_eq("rst_busy", o_busy, 0);
        check_eq("rst_ovf", o_overflow, 0);
        rst_n = 1'b1;

        bad = 0;
        repeat (100) begin
            tick();
            if (tx !== 1'b1 || o_empty !== 1'b1 || o_busy !== 1'b0 || o_level !== 3'd0) bad++;
        end
        check_eq("idle_stable", bad, 0);

        // Single byte A5
        t = cyc;
        i_wr_en = 1'b1;
        i_wr_data = 8'hA5;
        tick();
        i_wr_en = 1'b0;
        check_eq("a5_t1_tx", tx, 1);
        check_eq("a5_t1_level", o_level, 1);
        check_eq("a5_t1_busy", o_busy, 1);
        tick();
        check_eq("a5_fall", tx, 0);
        check_eq("a5_popped_empty", o_empty, 1);
        wait_frames(1, 400, "a5_count");
        check_eq("a5_bits", q_bits[0], 10'b1101001010);
        check_eq("a5_start", q_start[0], t + 2);
        while (cyc < t + 2 + FRAME - 1) tick();
        check_eq("a5_busy_last_stop", o_busy, 1);
        tick();
        check_eq("a5_busy_drop", o_busy, 0);
        bad = 0;
        repeat (30) begin
            if (tx !== 1'b1) bad++;
            tick();
        end
        check_eq("a5_tx_high_after", bad, 0);

        // Burst 01..05, drop 06, overflow set/clear/set-wins
        t = cyc;
        for (int i = 1; i <= 5; i++) begin
            i_wr_en = 1'b1;
            i_wr_data = 8'(i);
            tick();
        end
        check_eq("burst_full", o_full, 1);
        check_eq("burst_level", o_level, 4);
        check_eq("burst_ovf_pre", o_overflow, 0);
        i_wr_data = 8'h06;
        tick();
        i_wr_en = 1'b0;
        check_eq("ovf_set", o_overflow, 1);
        check_eq("ovf_level", o_level, 4);
        i_clr_ovf = 1'b1;
        tick();
        i_clr_ovf = 1'b0;
        check_eq("ovf_clr", o_overflow, 0);
        i_wr_en = 1'b1;
        i_wr_data = 8'h07;
        i_clr_ovf = 1'b1;
        tick();
        i_wr_en = 1'b0;
        i_clr_ovf = 1'b0;
        check_eq("ovf_set_wins", o_overflow, 1);
        i_clr_ovf = 1'b1;
        tick();
        i_clr_ovf = 1'b0;
        check_eq("ovf_clr2", o_overflow, 0);
        wait_frames(6, 5 * FRAME + 50, "burst_count");
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("burst_byte%0d", i), q_bits[1 + i], {1'b1, 8'(i + 1), 1'b0});
        end
        check_eq("burst_start", q_start[1], t + 2);
        for (int i = 1; i < 5; i++) begin
            check_eq($sformatf("burst_gap%0d", i), q_start[1 + i] - q_start[i], FRAME + 1);
        end
        repeat (FRAME + 20) tick();
        check_eq("burst_no_extra", q_bits.size(), 6);
        check_eq("burst_end_empty", o_empty, 1);
        check_eq("burst_end_busy", o_busy, 0);

        // Simultaneous write and pop with level 2
        sim_bytes[0] = 8'hAA;
        sim_bytes[1] = 8'hBB;
        sim_bytes[2] = 8'hCC;
        sim_bytes[3] = 8'hDD;
        t = cyc;
        for (int i = 0; i < 3; i++) begin
            i_wr_en = 1'b1;
            i_wr_data = sim_bytes[i];
            tick();
        end
        i_wr_en = 1'b0;
        s = t + 2;
        while (cyc < s + FRAME) tick();
        check_eq("sim_level_pre", o_level, 2);
        i_wr_en = 1'b1;
        i_wr_data = sim_bytes[3];
        tick();
        i_wr_en = 1'b0;
        check_eq("sim_level_post", o_level, 2);
        wait_frames(10, 4 * FRAME + 50, "sim_count");
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("sim_byte%0d", i), q_bits[6 + i], {1'b1, sim_bytes[i], 1'b0});
        end
        check_eq("sim_gap", q_start[7] - q_start[6], FRAME + 1);

        // Reset during DATA bit 3 of FF, with 3C still queued
        repeat (20) tick();
        t = cyc;
        i_wr_en = 1'b1;
        i_wr_data = 8'hFF;
        tick();
        i_wr_data = 8'h3C;
        tick();
        i_wr_en = 1'b0;
        s = t + 2;
        while (cyc < s + 4 * BD + 6) tick();
        check_eq("rmf_tx_pre", tx, 1);
        check_eq("rmf_busy_pre", o_busy, 1);
        check_eq("rmf_level_pre", o_level, 1);
        nfr = q_bits.size();
        rst_n = 1'b0;
        #1;
        check_eq("rmf_tx", tx, 1);
        check_eq("rmf_empty", o_empty, 1);
        check_eq("rmf_level", o_level, 0);
        check_eq("rmf_busy", o_busy, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        bad = 0;
        repeat (3 * FRAME) begin
            tick();
            if (tx !== 1'b1) bad++;
        end
        check_eq("rmf_no_residual_tx", bad, 0);
        check_eq("rmf_no_frame", q_bits.size(), nfr);
        check_eq("rmf_empty_after", o_empty, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
